mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares one single-port synchronous word RAM between the instruction-fetch port (I) and
//  the load/store data port (D). Round-robin arbitration on ties. Byte-enabled stores are
//  done as read-modify-write, because the RAM only writes whole words. Sits between the
//  CPU core and the RAM. The RAM returns read data one cycle after the address and is
//  write-first.
// PARAMETERS
//  N     32    data width in bits (multiple of 8)
//  SIZE  1024  RAM depth in words; AW = log2(SIZE) is the word-address width
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous reset, active low
//  i_req      in   1      instruction read request
//  i_addr     in   AW     instruction word address
//  i_gnt      out  1      I request accepted this cycle
//  i_rvalid   out  1      i_rdata valid
//  i_rdata    out  N      instruction read data
//  d_req      in   1      data request
//  d_we       in   1      1=store, 0=load
//  d_be       in   N/8    store byte enables; bit k covers byte k
//  d_addr     in   AW     data word address
//  d_wdata    in   N      store data (byte lanes in place)
//  d_gnt      out  1      D request accepted this cycle
//  d_rvalid   out  1      d_rdata valid (loads only)
//  d_rdata    out  N      load data
//  ram_we     out  1      RAM write enable
//  ram_addr   out  AW     RAM word address
//  ram_wdata  out  N      RAM write data
//  ram_rdata  in   N      RAM read data, valid 1 cycle after the address
// BEHAVIOUR
//  - States:
//      IDLE
//      RD    read response cycle; the response goes to the port held in rd_owner
//      MERGE second cycle of a read-modify-write
//  - Arbitration in IDLE and RD only:
//      * one requester: it wins
//      * both: the port not granted last wins (last_gnt register)
//      * gnt is combinational and is asserted in the same cycle as req
//      * the request completes on req & gnt; the requester may change or drop inputs next cycle
//      * no grant in MERGE; requesters hold req
//  - Grant cycle: ram_addr = winner address (combinational).
//      * read (I, or D with d_we=0): ram_we=0. Next state RD; rd_owner <= winner.
//      * full store (d_be all ones): ram_we=1, ram_wdata=d_wdata. Next state IDLE. No rvalid.
//      * partial store (d_be nonzero, not all ones): ram_we=0. Capture addr, be and wdata.
//        Next state MERGE.
//      * store with d_be=0: granted, ram_we=0, no effect. Next state IDLE.
//  - RD:
//      * the owner's rvalid = 1 for exactly this cycle; its rdata = ram_rdata
//      * a new grant here gives back-to-back reads (1 word/cycle)
//      * no new grant: next state IDLE
//  - MERGE:
//      * ram_we=1, ram_addr=captured addr
//      * ram_wdata byte k = be[k] ? wdata byte k : ram_rdata byte k
//      * next state IDLE
//      * partial store occupies the RAM for 2 cycles
//  - When neither rvalid is high, the rdata outputs equal ram_rdata and carry no meaning.
//  - Default outputs: ram_we=0, ram_wdata=0, ram_addr=0 when no grant and not in MERGE.
//  - Ordering: a store followed by a load to the same address returns the new data
//    (the RAM is write-first; MERGE writes before any later read).
//  - Reset (async, rst_n=0):
//      * state=IDLE, last_gnt=D (so I wins the first tie), rd_owner=I, captured regs=0
//      * gnt/rvalid/ram_we = 0 while rst_n=0
//      * reset during MERGE drops the write; the RAM word is unchanged
//      * a read pending in RD gets no rvalid
// TESTING
//  1. After reset, i_req, i_addr=0x010 (word 0x00000013) -> i_gnt same cycle;
//     i_rvalid=1 with i_rdata=0x00000013 next cycle only.
//  2. i_req and d_req (load) held for 4 cycles -> grants I,D,I,D; each rvalid one cycle
//     after its grant, on the correct port.
//  3. D store be=4'hF addr 5 data 0xDEADBEEF, then D load addr 5 -> d_rdata=0xDEADBEEF;
//     no d_rvalid for the store.
//  4. Word 0x11223344 at addr 7; D store be=4'b0010 wdata=0x0000AB00 with i_req held ->
//     MERGE writes 0x1122AB44; i_gnt held off in MERGE, granted the cycle after.
//  5. rst_n low during MERGE of test 4 -> ram_we stays 0; word stays 0x11223344;
//     all gnt/rvalid 0.
//  6. I reads addr 1,2,3 on consecutive cycles -> 3 consecutive i_rvalid cycles, data in order.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU-side ports, the arbiter and the single-port word RAM.
// The arbiter uses the slave view; the core/RAM side uses the master view.
interface mem_arbiter_if #(
    parameter int N  = 32,
    parameter int AW = 10
);
    logic            i_req;
    logic [AW-1:0]   i_addr;
    logic            i_gnt;
    logic            i_rvalid;
    logic [N-1:0]    i_rdata;
    logic            d_req;
    logic            d_we;
    logic [N/8-1:0]  d_be;
    logic [AW-1:0]   d_addr;
    logic [N-1:0]    d_wdata;
    logic            d_gnt;
    logic            d_rvalid;
    logic [N-1:0]    d_rdata;
    logic            ram_we;
    logic [AW-1:0]   ram_addr;
    logic [N-1:0]    ram_wdata;
    logic [N-1:0]    ram_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, ram_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        output ram_we, ram_addr, ram_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, ram_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        input  ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous word RAM between the
// instruction-fetch port and the load/store port; partial stores become read-modify-write.
module mem_arbiter #(
    parameter  int N    = 32,
    parameter  int SIZE = 1024,
    localparam int AW   = $clog2(SIZE)
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RD = 2'd1, ST_MERGE = 2'd2} state_e;
    typedef enum logic {PORT_I = 1'b0, PORT_D = 1'b1} port_e;

    state_e          state_q,     state_d;
    port_e           last_gnt_q,  last_gnt_d;
    port_e           rd_owner_q,  rd_owner_d;
    logic [AW-1:0]   cap_addr_q,  cap_addr_d;
    logic [N/8-1:0]  cap_be_q,    cap_be_d;
    logic [N-1:0]    cap_wdata_q, cap_wdata_d;

    logic            gnt_i_s;
    logic            gnt_d_s;
    logic            be_full_s;
    logic            be_none_s;

    function automatic logic [N-1:0] merge_bytes(input logic [N-1:0]   new_w,
                                                 input logic [N-1:0]   old_w,
                                                 input logic [N/8-1:0] be);
        logic [N-1:0] res;
        res = old_w;
        for (int k = 0; k < N/8; k++) begin
            res[8*k +: 8] = be[k] ? new_w[8*k +: 8] : old_w[8*k +: 8];
        end
        return res;
    endfunction

    assign be_full_s = &bus.d_be;
    assign be_none_s = ~|bus.d_be;

    // Arbitration: a tie goes to the port that did not win last time; MERGE blocks grants.
    always_comb begin
        gnt_i_s = 1'b0;
        gnt_d_s = 1'b0;
        if (rst_n && (state_q != ST_MERGE)) begin
            if (bus.i_req && (!bus.d_req || (last_gnt_q == PORT_D))) begin
                gnt_i_s = 1'b1;
            end else begin
                gnt_d_s = bus.d_req;
            end
        end else begin
            gnt_i_s = 1'b0;
            gnt_d_s = 1'b0;
        end
    end

    // State register with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            last_gnt_q  <= PORT_D;
            rd_owner_q  <= PORT_I;
            cap_addr_q  <= '0;
            cap_be_q    <= '0;
            cap_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            rd_owner_q  <= rd_owner_d;
            cap_addr_q  <= cap_addr_d;
            cap_be_q    <= cap_be_d;
            cap_wdata_q <= cap_wdata_d;
        end
    end

    // Next-state logic: grants start reads, full stores, or the read half of a merge.
    always_comb begin
        state_d     = state_q;
        last_gnt_d  = last_gnt_q;
        rd_owner_d  = rd_owner_q;
        cap_addr_d  = cap_addr_q;
        cap_be_d    = cap_be_q;
        cap_wdata_d = cap_wdata_q;
        case (state_q)
            ST_IDLE, ST_RD: begin
                if (gnt_i_s) begin
                    state_d    = ST_RD;
                    rd_owner_d = PORT_I;
                    last_gnt_d = PORT_I;
                end else if (gnt_d_s) begin
                    last_gnt_d = PORT_D;
                    if (!bus.d_we) begin
                        state_d    = ST_RD;
                        rd_owner_d = PORT_D;
                    end else if (be_full_s || be_none_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d     = ST_MERGE;
                        cap_addr_d  = bus.d_addr;
                        cap_be_d    = bus.d_be;
                        cap_wdata_d = bus.d_wdata;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MERGE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output logic: RAM drive, grants and read responses.
    always_comb begin
        bus.ram_we    = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_wdata = '0;
        if (rst_n && (state_q == ST_MERGE)) begin
            bus.ram_we    = 1'b1;
            bus.ram_addr  = cap_addr_q;
            bus.ram_wdata = merge_bytes(cap_wdata_q, bus.ram_rdata, cap_be_q);
        end else if (gnt_i_s) begin
            bus.ram_addr = bus.i_addr;
        end else if (gnt_d_s) begin
            bus.ram_addr = bus.d_addr;
            if (bus.d_we && be_full_s) begin
                bus.ram_we    = 1'b1;
                bus.ram_wdata = bus.d_wdata;
            end else begin
                bus.ram_we = 1'b0;
            end
        end else begin
            bus.ram_we = 1'b0;
        end
        bus.i_gnt    = gnt_i_s;
        bus.d_gnt    = gnt_d_s;
        bus.i_rvalid = rst_n && (state_q == ST_RD) && (rd_owner_q == PORT_I);
        bus.d_rvalid = rst_n && (state_q == ST_RD) && (rd_owner_q == PORT_D);
        bus.i_rdata  = bus.ram_rdata;
        bus.d_rdata  = bus.ram_rdata;
    end
endmodule
